// File: rtl/rf_wb_scoreboard.sv
// Write-side scoreboard for the pipeline RF: per-register pending-write counters, a registered RF write stage,
// and per-operand stall/bypass for decode. WB to rf_we takes 1 cycle; decode is held while a hazard or a full counter exists.
module rf_wb_scoreboard #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        id_valid,
  input  logic        id_we,
  input  logic [4:0]  id_wr,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic        wb_valid,
  input  logic        wb_we,
  input  logic [4:0]  wb_wr,
  input  logic [31:0] wb_wd,
  output logic        rf_we,
  output logic [4:0]  rf_wr,
  output logic [31:0] rf_wd,
  output logic        stall,
  output logic        byp1,
  output logic        byp2,
  output logic        err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [31:0][CNT_W-1:0] r_cnt;
  logic [31:0][CNT_W-1:0] w_cnt_nxt;
  logic                   r_rf_we;
  logic [4:0]             r_rf_wr;
  logic [31:0]            r_rf_wd;
  logic                   r_err;

  logic                   w_hit1, w_hit2, w_hitw;
  logic [CNT_W-1:0]       w_eff1, w_eff2, w_effw;
  logic                   w_haz1, w_haz2, w_full;
  logic                   w_stall, w_issue, w_err_set;
  logic [31:0]            w_inc, w_dec;

  // A write committing this cycle is no longer pending from the reader's view.
  assign w_hit1 = r_rf_we & (r_rf_wr == id_rs1);
  assign w_hit2 = r_rf_we & (r_rf_wr == id_rs2);
  assign w_hitw = r_rf_we & (r_rf_wr == id_wr);

  assign w_eff1 = r_cnt[id_rs1] - CNT_W'(w_hit1);
  assign w_eff2 = r_cnt[id_rs2] - CNT_W'(w_hit2);
  assign w_effw = r_cnt[id_wr]  - CNT_W'(w_hitw);

  assign w_haz1 = id_use1 & (|id_rs1) & (|w_eff1);
  assign w_haz2 = id_use2 & (|id_rs2) & (|w_eff2);
  assign w_full = id_valid & id_we & (|id_wr) & (w_effw == MAX_CNT);

  assign w_stall = id_valid & (w_haz1 | w_haz2 | w_full);
  assign w_issue = id_valid & id_we & (|id_wr) & ~w_stall;

  assign w_inc = {31'd0, w_issue} << id_wr;
  assign w_dec = {31'd0, r_rf_we} << r_rf_wr;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_err_set = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (w_dec[i] && (r_cnt[i] == '0)) begin
        w_err_set = 1'b1;
      end else if (w_dec[i] && !w_inc[i]) begin
        w_cnt_nxt[i] = r_cnt[i] - ONE;
      end else if (w_inc[i] && !w_dec[i]) begin
        if (r_cnt[i] == MAX_CNT) begin
          w_err_set = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_rf_we <= 1'b0;
      r_rf_wr <= 5'd0;
      r_rf_wd <= 32'd0;
      r_err   <= 1'b0;
    end else if (clr) begin
      r_cnt   <= '0;
      r_rf_we <= 1'b0;
      r_rf_wr <= wb_wr;
      r_rf_wd <= wb_wd;
      r_err   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_rf_we <= wb_valid & wb_we & (|wb_wr);
      r_rf_wr <= wb_wr;
      r_rf_wd <= wb_wd;
      r_err   <= r_err | w_err_set;
    end
  end

  assign rf_we = r_rf_we;
  assign rf_wr = r_rf_wr;
  assign rf_wd = r_rf_wd;
  assign err   = r_err;
  assign stall = w_stall;
  assign byp1  = id_use1 & (|id_rs1) & w_hit1 & ~(|w_eff1);
  assign byp2  = id_use2 & (|id_rs2) & w_hit2 & ~(|w_eff2);

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Bench for rf_wb_scoreboard: directed scenarios plus random traffic against a pending-write count model.
module tb_rf_wb_scoreboard;
  localparam int MAXI = 3;
  localparam int MOD  = 4;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic        id_valid, id_we, id_use1, id_use2;
  logic [4:0]  id_wr, id_rs1, id_rs2;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_wr;
  logic [31:0] wb_wd;
  logic        rf_we, stall, byp1, byp2, err;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;

  always #5 clk = ~clk;

  rf_wb_scoreboard #(.MAX_INFLIGHT(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .id_valid(id_valid), .id_we(id_we), .id_wr(id_wr),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_wr(wb_wr), .wb_wd(wb_wd),
    .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd),
    .stall(stall), .byp1(byp1), .byp2(byp2), .err(err)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          cnt[32];     // issued writes per register not yet committed to the RF
  bit          m_pwe, m_err;
  int          m_pwr;
  logic [31:0] m_pwd;
  int          q[$];        // issued destinations awaiting writeback

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int r);
    int e;
    e = cnt[r] - ((m_pwe && m_pwr == r) ? 1 : 0);
    return (e + MOD) % MOD;
  endfunction

  function automatic bit haz(input bit u, input int rs);
    return u && rs != 0 && eff(rs) != 0;
  endfunction

  function automatic bit byp(input bit u, input int rs);
    return u && rs != 0 && m_pwe && m_pwr == rs && eff(rs) == 0;
  endfunction

  function automatic bit stall_m();
    bit full;
    full = id_valid && id_we && id_wr != 0 && eff(int'(id_wr)) == MAXI;
    return id_valid && (haz(id_use1, int'(id_rs1)) || haz(id_use2, int'(id_rs2)) || full);
  endfunction

  task automatic model_reset();
    foreach (cnt[i]) cnt[i] = 0;
    m_pwe = 0; m_err = 0; m_pwr = 0; m_pwd = 32'd0;
    q.delete();
  endtask

  task automatic set_id(input logic v, input logic we, input logic [4:0] wr,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
    id_valid = v; id_we = we; id_wr = wr;
    id_rs1 = rs1; id_use1 = u1; id_rs2 = rs2; id_use2 = u2;
  endtask

  task automatic set_wb(input logic v, input logic we, input logic [4:0] wr, input logic [31:0] wd);
    wb_valid = v; wb_we = we; wb_wr = wr; wb_wd = wd;
  endtask

  task automatic settle();
    #1;
    chk("rf_we", rf_we, m_pwe);
    chk("rf_wr", rf_wr, m_pwr);
    chk("rf_wd", rf_wd, m_pwd);
    chk("err",   err,   m_err);
    chk("stall", stall, stall_m());
    chk("byp1",  byp1,  byp(id_use1, int'(id_rs1)));
    chk("byp2",  byp2,  byp(id_use2, int'(id_rs2)));
  endtask

  task automatic advance();
    bit iss;
    int w;
    iss = id_valid && id_we && id_wr != 0 && !stall_m();
    w   = int'(id_wr);
    if (clr) begin
      foreach (cnt[i]) cnt[i] = 0;
      m_err = 0; m_pwe = 0;
      q.delete();
    end else begin
      if (m_pwe) begin
        if (cnt[m_pwr] == 0) m_err = 1;
        else if (!(iss && w == m_pwr)) cnt[m_pwr]--;
      end
      if (iss) begin
        if (!(m_pwe && m_pwr == w)) begin
          if (cnt[w] == MAXI) m_err = 1;
          else cnt[w]++;
        end
        q.push_back(w);
      end
      m_pwe = wb_valid && wb_we && wb_wr != 0;
    end
    m_pwr = int'(wb_wr);
    m_pwd = wb_wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int w;
    rst = 1'b1; clr = 1'b0;
    set_id(0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    set_wb(0, 0, 5'd0, 32'd0);
    model_reset();

    // reset state
    @(negedge clk);
    settle();
    rst = 1'b0;
    advance();

    // single RAW on x5
    set_id(1, 1, 5'd5, 5'd0, 0, 5'd0, 0); settle(); advance();
    set_id(1, 0, 5'd0, 5'd5, 1, 5'd0, 0); set_wb(1, 1, 5'd5, 32'h0000_1234);
    settle(); chk("raw_stall", stall, 1); advance();
    set_wb(0, 0, 5'd0, 32'd0);
    settle();
    chk("raw_we", rf_we, 1); chk("raw_wr", rf_wr, 5); chk("raw_wd", rf_wd, 32'h1234);
    chk("raw_byp", byp1, 1); chk("raw_nostall", stall, 0);
    advance();
    settle(); chk("raw_byp_done", byp1, 0); advance();

    // two writes in flight to x7
    set_id(1, 1, 5'd7, 5'd0, 0, 5'd0, 0); settle(); advance(); settle(); advance();
    set_id(0, 0, 5'd0, 5'd0, 0, 5'd0, 0); set_wb(1, 1, 5'd7, 32'h77); settle(); advance();
    set_id(1, 0, 5'd0, 5'd7, 1, 5'd0, 0); set_wb(1, 1, 5'd7, 32'h78);
    settle(); chk("dbl1_stall", stall, 1); chk("dbl1_byp", byp1, 0); advance();
    set_wb(0, 0, 5'd0, 32'd0);
    settle(); chk("dbl2_stall", stall, 0); chk("dbl2_byp", byp1, 1); chk("dbl2_wd", rf_wd, 32'h78);
    advance();

    // x0 is never tracked
    set_id(1, 1, 5'd0, 5'd0, 1, 5'd0, 1); set_wb(1, 1, 5'd0, 32'hDEAD_BEEF);
    settle(); chk("x0_stall", stall, 0); advance();
    set_id(0, 0, 5'd0, 5'd0, 0, 5'd0, 0); set_wb(0, 0, 5'd0, 32'd0);
    settle(); chk("x0_we", rf_we, 0); advance();

    // issue x9 while x9 retires
    set_id(1, 1, 5'd9, 5'd0, 0, 5'd0, 0); settle(); advance();
    set_id(0, 0, 5'd0, 5'd0, 0, 5'd0, 0); set_wb(1, 1, 5'd9, 32'h99); settle(); advance();
    set_id(1, 1, 5'd9, 5'd0, 0, 5'd0, 0); set_wb(0, 0, 5'd0, 32'd0);
    settle(); chk("x9_issue", stall, 0); chk("x9_retire", rf_we, 1); advance();
    set_id(1, 0, 5'd0, 5'd0, 0, 5'd9, 1);
    settle(); chk("x9_stall", stall, 1); advance();
    set_id(0, 0, 5'd0, 5'd0, 0, 5'd0, 0); set_wb(1, 1, 5'd9, 32'h9A); settle(); advance();
    set_wb(0, 0, 5'd0, 32'd0); settle(); advance();

    // capacity on x3
    set_id(1, 1, 5'd3, 5'd0, 0, 5'd0, 0);
    repeat (3) begin settle(); chk("cap_issue", stall, 0); advance(); end
    settle(); chk("cap_full", stall, 1); advance();
    set_id(0, 0, 5'd0, 5'd0, 0, 5'd0, 0); set_wb(1, 1, 5'd3, 32'h33);
    repeat (3) begin settle(); advance(); end
    set_wb(0, 0, 5'd0, 32'd0); settle(); advance(); settle(); advance();

    // underflow, sticky err, clr
    set_id(1, 1, 5'd6, 5'd0, 0, 5'd0, 0); settle(); advance();
    set_id(0, 0, 5'd0, 5'd0, 0, 5'd0, 0); set_wb(1, 1, 5'd4, 32'h44); settle(); advance();
    set_wb(0, 0, 5'd0, 32'd0); settle(); advance();
    settle(); chk("err_set", err, 1); advance();
    settle(); chk("err_sticky", err, 1);
    clr = 1'b1; advance(); clr = 1'b0;
    set_id(1, 0, 5'd0, 5'd6, 1, 5'd0, 0);
    settle(); chk("clr_err", err, 0); chk("clr_cnt", stall, 0); advance();

    // asynchronous reset while a write is pending
    set_id(1, 1, 5'd5, 5'd0, 0, 5'd0, 0); settle(); advance(); settle(); advance();
    set_id(0, 0, 5'd0, 5'd0, 0, 5'd0, 0); set_wb(1, 1, 5'd5, 32'h55); settle(); advance();
    set_wb(0, 0, 5'd0, 32'd0);
    settle(); chk("mid_we", rf_we, 1);
    #1 rst = 1'b1;
    #1 chk("rst_async_we", rf_we, 0);
    model_reset();
    @(negedge clk);
    set_id(1, 0, 5'd0, 5'd5, 1, 5'd0, 0);
    settle(); chk("rst_stall", stall, 0); chk("rst_byp", byp1, 0); chk("rst_err", err, 0);
    rst = 1'b0;
    advance();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      set_id(1'($urandom % 2), 1'($urandom % 2), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom % 2), 5'($urandom_range(0, 7)), 1'($urandom % 2));
      if (q.size() > 0 && ($urandom % 2) == 1) begin
        w = q.pop_front();
        set_wb(1, 1, 5'(w), $urandom);
      end else begin
        set_wb(1'($urandom % 2), 1'($urandom % 2), 5'd0, $urandom);
      end
      clr = (($urandom % 200) == 0);
      settle();
      advance();
    end
    clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rf_wb_scoreboard.md
Name: rf_wb_scoreboard

Overview:
- Write-side companion to the pipeline register file.
- Tracks in-flight destination writes issued from decode and registers writeback results into the RF write port (rf_we/rf_wr/rf_wd).
- Gives decode per-operand stall and bypass information, since an RF write commits only on the clock edge and a same-cycle read sees the old value.
- Sits between the ID and WB stages; its outputs drive the RF write port directly.

Parameters:
- MAX_INFLIGHT, 3, max outstanding writes per architectural register (5-stage pipe needs 3).
- CNT_W, 2, width of each per-register pending counter; must hold MAX_INFLIGHT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of all counters and the RF write stage
- id_valid  in  1  decode holds a valid instruction
- id_we  in  1  instruction writes a destination register
- id_wr  in  5  destination register number
- id_rs1  in  5  source register 1 (same value as RF rR1)
- id_rs2  in  5  source register 2 (same value as RF rR2)
- id_use1  in  1  rs1 is actually read
- id_use2  in  1  rs2 is actually read
- wb_valid  in  1  writeback stage holds a valid result
- wb_we  in  1  result is written to a register
- wb_wr  in  5  result destination
- wb_wd  in  32  result data
- rf_we  out  1  RF write enable
- rf_wr  out  5  RF write register
- rf_wd  out  32  RF write data
- stall  out  1  decode must hold; instruction is not issued
- byp1  out  1  replace RF rD1 with rf_wd this cycle
- byp2  out  1  replace RF rD2 with rf_wd this cycle
- err  out  1  sticky counter underflow/overflow flag

Behaviour:
- Reset (async): all 32 counters = 0; rf_we = 0; rf_wr = 0; rf_wd = 0; err = 0. stall/byp1/byp2 are combinational and evaluate to 0 after reset.
- Register 0 is never tracked:
  - Issue or retire with wr = 0 leaves counters unchanged.
  - A wb with wb_wr = 0 produces rf_we = 0.
  - Operands equal to 0 never stall or bypass.
- Retire path:
  - Edge k: rf_we <= wb_valid & wb_we & (wb_wr != 0); rf_wr <= wb_wr; rf_wd <= wb_wd.
  - rf_wr/rf_wd update on every edge; their value matters only when rf_we = 1.
  - Latency: wb to rf_we is 1 cycle; the RF commits at edge k+1.
  - cnt[rf_wr] decrements at the same edge k+1, while rf_we = 1.
- Issue path:
  - issue = id_valid & id_we & (id_wr != 0) & ~stall.
  - cnt[id_wr] increments at the next edge.
- Hazard, per operand n (n = 1 or 2):
  - eff_n = cnt[rsn] - (rf_we & rf_wr == rsn).
  - haz_n = use_n & (rsn != 0) & (eff_n != 0).
  - byp_n = use_n & (rsn != 0) & rf_we & (rf_wr == rsn) & (eff_n == 0).
- Capacity stall: full = id_valid & id_we & (id_wr != 0) & (eff_wr == MAX_INFLIGHT), where eff_wr is computed the same way for id_wr.
- stall = id_valid & (haz_1 | haz_2 | full).
- Simultaneous issue and retire to the same register: net counter unchanged (+1 - 1).
- Underflow: rf_we with cnt[rf_wr] = 0 leaves the counter at 0 and sets err.
- Overflow: an increment that would exceed MAX_INFLIGHT sets err. This is unreachable while the capacity stall is obeyed.
- err clears only on rst or clr.
- clr (synchronous, takes priority over issue and retire):
  - Next edge: counters = 0, rf_we = 0, err = 0.
  - A pending RF write in the same cycle is still committed by the RF.
- Counter arithmetic is modulo 2^CNT_W. eff_n never goes negative, because rf_we implies cnt ≥ 1 unless err.

Test Plan:
- Reset mid-operation: cnt[5] = 2, rf_we = 1 → assert rst asynchronously → rf_we = 0 immediately; later rs1 = 5, use1 = 1 gives stall = 0, byp1 = 0; err = 0.
- Single RAW: issue x5 → rs1 = 5 stalls; wb x5 = 0x0000_1234 at edge k → cycle k+1: rf_we = 1, rf_wr = 5, rf_wd = 0x1234, byp1 = 1, stall = 0; edge k+1: cnt[5] = 0, byp1 = 0.
- Double in-flight to x7: two issues to x7 (cnt = 2) → during the first rf_we to x7: stall = 1, byp = 0; during the second: stall = 0, byp1 = 1.
- x0: issue and wb to x0 with data 0xDEAD_BEEF → rf_we stays 0, no counter change, rs1 = 0 never stalls.
- Same-cycle issue of x9 while rf_we retires x9 (cnt = 1) → cnt[9] stays 1; next cycle rs2 = 9 stalls.
- Error/capacity:
  - Three issues to x3 → the fourth is held by full stall.
  - wb to x4 with cnt[4] = 0 → err = 1 sticky until clr; clr zeroes all counters.
